// File: rtl/squash_adapter_pkg.sv
// Shared register map and bit positions for the Caravel squash adapter.
package squash_adapter_pkg;

  typedef enum logic [1:0] {
    RegCtrl   = 2'd0,
    RegStatus = 2'd1,
    RegPads   = 2'd2,
    RegIrq    = 2'd3
  } reg_idx_e;

  localparam int unsigned CtrlEnBit        = 0;
  localparam int unsigned CtrlSrstBit      = 1;
  localparam int unsigned CtrlIrqEnBit     = 2;
  localparam logic [31:0] CtrlRstVal       = 32'h0000_0001;

  localparam int unsigned StatusReadyBit   = 0;
  localparam int unsigned StatusCoreRstBit = 1;
  localparam int unsigned StatusBtnLsb     = 8;

  localparam int unsigned IrqPendBit       = 0;
  localparam int unsigned IrqCountLsb      = 16;

  // Replace only the byte lanes enabled in sel.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/squash_caravel_adapter_if.sv
// Wishbone classic slave bundle between user_project_wrapper and the squash adapter.
interface squash_caravel_adapter_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/squash_debounce.sv
// Single-button synchroniser and debouncer; CYCLES=0 leaves only the 2-flop sync.
module squash_debounce #(
  parameter int unsigned CYCLES = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_clean
);

  logic r_meta, r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
    end
  end

  if (CYCLES == 0) begin : g_bypass
    assign o_clean = r_sync;
  end else begin : g_filter
    localparam int unsigned CntW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CYCLES - 1);

    logic [CntW-1:0] r_cnt;
    logic            r_clean;

    // Counts consecutive samples that disagree with the accepted level.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_cnt   <= '0;
        r_clean <= 1'b0;
      end else if (r_sync == r_clean) begin
        r_cnt <= '0;
      end else if (r_cnt == CntMax) begin
        r_cnt   <= '0;
        r_clean <= r_sync;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign o_clean = r_clean;
  end

endmodule

// File: rtl/squash_caravel_adapter.sv
// Caravel pad/reset/Wishbone adapter for the solo_squash core.
// Define SQUASH_ADAPTER_IRQ_EN to build the vsync interrupt and frame counter.
module squash_caravel_adapter
  import squash_adapter_pkg::*;
#(
  parameter int unsigned IO_PADS         = 38,
  parameter int unsigned NUM_IN          = 4,
  parameter int unsigned NUM_OUT         = 8,
  parameter int unsigned IN_BASE         = 8,
  parameter int unsigned OUT_BASE        = 16,
  parameter int unsigned READY_BIT       = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned SOFT_RST_CYCLES = 16,
  parameter int unsigned VSYNC_IDX       = 1,
  parameter logic [31:0] WB_BASE         = 32'h3000_0000
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  squash_caravel_adapter_if.slave wbs,
  input  logic [127:0]           la_data_in,
  input  logic [IO_PADS-1:0]     io_in,
  output logic [IO_PADS-1:0]     io_out,
  output logic [IO_PADS-1:0]     io_oeb,
  output logic                   core_rst_o,
  output logic [NUM_IN-1:0]      core_btn_o,
  input  logic [NUM_OUT-1:0]     core_out_i,
  output logic [2:0]             user_irq
);

  localparam int unsigned SrstW = (SOFT_RST_CYCLES > 0) ? $clog2(SOFT_RST_CYCLES + 1) : 1;

  logic              r_ready_meta, r_ready;
  logic              r_ctrl_en;
  logic [SrstW-1:0]  r_srst_cnt;
  logic              r_core_rst;
  logic [NUM_OUT-1:0] r_pads;
  logic              r_ack;
  logic [31:0]       r_dat;

  logic              w_req, w_hit, w_wr, w_ctrl_wr, w_irq_en;
  reg_idx_e          w_reg;
  logic [31:0]       w_ctrl_old, w_ctrl_new, w_rdata, w_irq_rdata;

  assign w_req     = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~r_ack;
  assign w_hit     = wbs.wbs_adr_i[31:4] == WB_BASE[31:4];
  assign w_wr      = w_req & w_hit & wbs.wbs_we_i;
  assign w_reg     = reg_idx_e'(wbs.wbs_adr_i[3:2]);
  assign w_ctrl_wr = w_wr & (w_reg == RegCtrl);

  always_comb begin
    w_ctrl_old               = '0;
    w_ctrl_old[CtrlEnBit]    = r_ctrl_en;
    w_ctrl_old[CtrlIrqEnBit] = w_irq_en;
  end

  assign w_ctrl_new = byte_merge(w_ctrl_old, wbs.wbs_dat_i, wbs.wbs_sel_i);

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      RegCtrl:   w_rdata = w_ctrl_old;
      RegStatus: begin
        w_rdata[StatusReadyBit]           = r_ready;
        w_rdata[StatusCoreRstBit]         = r_core_rst;
        w_rdata[StatusBtnLsb +: NUM_IN]   = core_btn_o;
      end
      RegPads:   w_rdata[NUM_OUT-1:0] = r_pads;
      RegIrq:    w_rdata = w_irq_rdata;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ready_meta <= 1'b0;
      r_ready      <= 1'b0;
      r_ctrl_en    <= CtrlRstVal[CtrlEnBit];
      r_srst_cnt   <= '0;
      r_core_rst   <= 1'b1;
      r_pads       <= '0;
      r_ack        <= 1'b0;
      r_dat        <= '0;
    end else begin
      r_ready_meta <= la_data_in[READY_BIT];
      r_ready      <= r_ready_meta;
      if (w_ctrl_wr) r_ctrl_en <= w_ctrl_new[CtrlEnBit];
      // Soft-reset bit is write-one-to-start; a rewrite restarts the stretch.
      if (w_ctrl_wr && w_ctrl_new[CtrlSrstBit]) r_srst_cnt <= SrstW'(SOFT_RST_CYCLES);
      else if (r_srst_cnt != '0)                r_srst_cnt <= r_srst_cnt - 1'b1;
      r_core_rst <= ~r_ready | ~r_ctrl_en | (r_srst_cnt != '0);
      r_pads     <= core_out_i;
      r_ack      <= w_req;
      r_dat      <= (w_req && !wbs.wbs_we_i && w_hit) ? w_rdata : '0;
    end
  end

  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_dat_o = r_dat;
  assign core_rst_o    = r_core_rst;

  always_comb begin
    io_out = '0;
    io_oeb = '1;
    io_out[OUT_BASE +: NUM_OUT] = r_pads;
    io_oeb[OUT_BASE +: NUM_OUT] = {NUM_OUT{~r_ready}};
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_btn
    squash_debounce #(
      .CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .i_clk  (wb_clk_i),
      .i_rst  (wb_rst_i),
      .i_raw  (io_in[IN_BASE + i]),
      .o_clean(core_btn_o[i])
    );
  end

`ifdef SQUASH_ADAPTER_IRQ_EN
  logic        r_irq_en, r_vsync, r_pending, r_user_irq;
  logic [15:0] r_frames;
  logic        w_edge, w_clr;

  assign w_edge = core_out_i[VSYNC_IDX] & ~r_vsync;
  assign w_clr  = w_wr & (w_reg == RegIrq) & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[IrqPendBit];

  // A vsync edge beats a same-cycle clear so no frame is lost.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_irq_en   <= CtrlRstVal[CtrlIrqEnBit];
      r_vsync    <= 1'b0;
      r_pending  <= 1'b0;
      r_frames   <= '0;
      r_user_irq <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_irq_en <= w_ctrl_new[CtrlIrqEnBit];
      r_vsync <= core_out_i[VSYNC_IDX];
      if (w_edge) begin
        r_pending <= 1'b1;
        r_frames  <= r_frames + 16'd1;
      end else if (w_clr) begin
        r_pending <= 1'b0;
      end
      r_user_irq <= r_pending & r_irq_en;
    end
  end

  assign w_irq_en = r_irq_en;
  always_comb begin
    w_irq_rdata                     = '0;
    w_irq_rdata[IrqPendBit]         = r_pending;
    w_irq_rdata[IrqCountLsb +: 16]  = r_frames;
  end
  assign user_irq = {2'b00, r_user_irq};
`else
  assign w_irq_en    = 1'b0;
  assign w_irq_rdata = '0;
  assign user_irq    = '0;
`endif

  logic w_unused;
  assign w_unused = ^{la_data_in, io_in, wbs.wbs_adr_i[1:0], w_ctrl_new, core_out_i[VSYNC_IDX]};

endmodule
